decode_stage: RTL and testbench

- D stage of the 5-stage MIPS pipeline; consumes the F-stage registered outputs (PC, instruction word).
- Returns the control pair that F consumes: redirect (ifjump/jumppc) and stall (zuse).
- Contains the 32x32 GPR file, resolves branches/jumps in D (one delay slot, no flush), detects hazards that must stall, and registers the D/E pipeline latch.

---
 rtl/decode_stage.sv | 229 ++++++++++++++++++++++
 tb/tb_decode_stage.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/decode_stage.sv
// Decode stage of the 5-stage MIPS pipeline.
// Holds the GPR file and resolves branches and jumps in D, with one delay slot
// and no flush. Raises the F/D stall for hazards that forwarding cannot cover,
// and registers the D/E pipeline latch.
module decode_stage #(
  parameter logic [31:0] RESET_PC = 32'h3000,
  parameter int          NUM_REGS = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] f_pc,
  input  logic [31:0] f_instr,
  output logic        ifjump,
  output logic [31:0] jumppc,
  output logic        zuse,
  input  logic [4:0]  e_wr_addr,
  input  logic        e_we,
  input  logic        e_is_load,
  input  logic [4:0]  m_wr_addr,
  input  logic        m_we,
  input  logic        m_is_load,
  input  logic [31:0] m_data,
  input  logic        w_we,
  input  logic [4:0]  w_addr,
  input  logic [31:0] w_data,
  output logic [31:0] de_pc,
  output logic [31:0] de_instr,
  output logic [31:0] de_rs_val,
  output logic [31:0] de_rt_val,
  output logic [31:0] de_imm,
  output logic        de_valid
);

  localparam logic [5:0] OPC_RTYPE = 6'h00;
  localparam logic [5:0] OPC_J     = 6'h02;
  localparam logic [5:0] OPC_JAL   = 6'h03;
  localparam logic [5:0] OPC_BEQ   = 6'h04;
  localparam logic [5:0] OPC_BNE   = 6'h05;
  localparam logic [5:0] OPC_ORI   = 6'h0d;
  localparam logic [5:0] OPC_LUI   = 6'h0f;
  localparam logic [5:0] OPC_LW    = 6'h23;
  localparam logic [5:0] OPC_SW    = 6'h2b;
  localparam logic [5:0] FN_JR     = 6'h08;
  localparam logic [5:0] FN_ADDU   = 6'h21;
  localparam logic [5:0] FN_SUBU   = 6'h23;

  typedef enum logic [3:0] {
    OP_NOP, OP_ADDU, OP_SUBU, OP_ORI, OP_LUI, OP_LW, OP_SW,
    OP_BEQ, OP_BNE, OP_J, OP_JAL, OP_JR
  } op_t;

  logic [31:0] r_gpr [NUM_REGS];

  op_t         w_op;
  logic [4:0]  w_rs;
  logic [4:0]  w_rt;
  logic [15:0] w_imm16;
  logic [31:0] w_sext;
  logic [31:0] w_imm;
  logic [31:0] w_rs_gpr;
  logic [31:0] w_rt_gpr;
  logic [31:0] w_rs_cmp;
  logic [31:0] w_rt_cmp;
  logic        w_use_rs;
  logic        w_use_rt;
  logic        w_cmp_rs;
  logic        w_cmp_rt;
  logic        w_load_use;
  logic        w_cmp_hazard;
  logic        w_taken;

  assign w_rs    = f_instr[25:21];
  assign w_rt    = f_instr[20:16];
  assign w_imm16 = f_instr[15:0];
  assign w_sext  = {{16{w_imm16[15]}}, w_imm16};

  // GPR file: synchronous clear on reset, W-stage write otherwise; $0 never written.
  // NOTE: the register file is cleared by reset because software may read a
  // GPR before writing it; sequential state always uses non-blocking (<=) so
  // every flop samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) r_gpr[i] <= '0;
    end else if (w_we && w_addr != 5'd0) begin
      r_gpr[w_addr] <= w_data;
    end
  end

  // Register reads with same-cycle W bypass; $0 reads as zero.
  assign w_rs_gpr = (w_rs == 5'd0) ? 32'd0 :
                    (w_we && w_addr == w_rs) ? w_data : r_gpr[w_rs];
  assign w_rt_gpr = (w_rt == 5'd0) ? 32'd0 :
                    (w_we && w_addr == w_rt) ? w_data : r_gpr[w_rt];

  // Comparator operands: take the M-stage ALU/link result when it targets the source.
  assign w_rs_cmp = (m_we && !m_is_load && m_wr_addr != 5'd0 && m_wr_addr == w_rs)
                    ? m_data : w_rs_gpr;
  assign w_rt_cmp = (m_we && !m_is_load && m_wr_addr != 5'd0 && m_wr_addr == w_rt)
                    ? m_data : w_rt_gpr;

  // Instruction decode; anything outside the supported set behaves as nop.
  // NOTE: every signal assigned in an always_comb gets a default first, so no
  // path through the case statement can leave it unassigned and infer a latch.
  always_comb begin
    w_op = OP_NOP;
    case (f_instr[31:26])
      OPC_RTYPE: begin
        case (f_instr[5:0])
          FN_ADDU: w_op = OP_ADDU;
          FN_SUBU: w_op = OP_SUBU;
          FN_JR:   w_op = OP_JR;
          default: w_op = OP_NOP;
        endcase
      end
      OPC_J:   w_op = OP_J;
      OPC_JAL: w_op = OP_JAL;
      OPC_BEQ: w_op = OP_BEQ;
      OPC_BNE: w_op = OP_BNE;
      OPC_ORI: w_op = OP_ORI;
      OPC_LUI: w_op = OP_LUI;
      OPC_LW:  w_op = OP_LW;
      OPC_SW:  w_op = OP_SW;
      default: w_op = OP_NOP;
    endcase
  end

  // Source usage flags and the subset of sources that feed the D comparator.
  always_comb begin
    w_use_rs = 1'b0;
    w_use_rt = 1'b0;
    w_cmp_rs = 1'b0;
    w_cmp_rt = 1'b0;
    case (w_op)
      OP_ADDU, OP_SUBU, OP_SW: begin
        w_use_rs = 1'b1;
        w_use_rt = 1'b1;
      end
      OP_ORI, OP_LW: w_use_rs = 1'b1;
      OP_BEQ, OP_BNE: begin
        w_use_rs = 1'b1;
        w_use_rt = 1'b1;
        w_cmp_rs = 1'b1;
        w_cmp_rt = 1'b1;
      end
      OP_JR: begin
        w_use_rs = 1'b1;
        w_cmp_rs = 1'b1;
      end
      default: ;
    endcase
  end

  // Stall detection: load-use on any source, or a comparator source still in flight.
  always_comb begin
    w_load_use = e_is_load && e_wr_addr != 5'd0 &&
                 ((w_use_rs && w_rs == e_wr_addr) || (w_use_rt && w_rt == e_wr_addr));
    w_cmp_hazard =
      (e_we && e_wr_addr != 5'd0 &&
       ((w_cmp_rs && w_rs == e_wr_addr) || (w_cmp_rt && w_rt == e_wr_addr))) ||
      (m_is_load && m_wr_addr != 5'd0 &&
       ((w_cmp_rs && w_rs == m_wr_addr) || (w_cmp_rt && w_rt == m_wr_addr)));
  end

  assign zuse = !reset && (w_load_use || w_cmp_hazard);

  // Branch decision and redirect target.
  always_comb begin
    w_taken = 1'b0;
    jumppc  = 32'd0;
    case (w_op)
      OP_BEQ: begin
        w_taken = (w_rs_cmp == w_rt_cmp);
        jumppc  = f_pc + 32'd4 + {w_sext[29:0], 2'b00};
      end
      OP_BNE: begin
        w_taken = (w_rs_cmp != w_rt_cmp);
        jumppc  = f_pc + 32'd4 + {w_sext[29:0], 2'b00};
      end
      OP_J, OP_JAL: begin
        w_taken = 1'b1;
        jumppc  = {f_pc[31:28], f_instr[25:0], 2'b00};
      end
      OP_JR: begin
        w_taken = 1'b1;
        jumppc  = w_rs_cmp;
      end
      default: ;
    endcase
  end

  // F gives the redirect priority over the stall, so a stalled branch must not redirect.
  assign ifjump = !reset && !zuse && w_taken;

  // Immediate shaping for E.
  always_comb begin
    case (w_op)
      OP_ORI:  w_imm = {16'h0, w_imm16};
      OP_LUI:  w_imm = {w_imm16, 16'h0};
      default: w_imm = w_sext;
    endcase
  end

  // D/E latch: reset wins over a stall; a stall inserts a bubble while F holds.
  always_ff @(posedge clk) begin
    if (reset) begin
      de_pc     <= RESET_PC;
      de_instr  <= '0;
      de_rs_val <= '0;
      de_rt_val <= '0;
      de_imm    <= '0;
      de_valid  <= 1'b0;
    end else if (zuse) begin
      de_pc     <= f_pc;
      de_instr  <= '0;
      de_rs_val <= '0;
      de_rt_val <= '0;
      de_imm    <= '0;
      de_valid  <= 1'b0;
    end else begin
      de_pc     <= f_pc;
      de_instr  <= f_instr;
      de_rs_val <= w_rs_gpr;
      de_rt_val <= w_rt_gpr;
      de_imm    <= w_imm;
      de_valid  <= 1'b1;
    end
  end

endmodule

// File: tb/tb_decode_stage.sv
// Self-checking bench for decode_stage: directed scenarios followed by random
// instruction streams compared against an instruction-level reference model.
module tb_decode_stage;

  localparam logic [31:0] RESET_PC = 32'h3000;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] f_pc, f_instr;
  logic        ifjump, zuse;
  logic [31:0] jumppc;
  logic [4:0]  e_wr_addr, m_wr_addr, w_addr;
  logic        e_we, e_is_load, m_we, m_is_load, w_we;
  logic [31:0] m_data, w_data;
  logic [31:0] de_pc, de_instr, de_rs_val, de_rt_val, de_imm;
  logic        de_valid;

  int total = 0;
  int bad   = 0;

  // Captured combinational outputs of the most recent step.
  logic        c_zuse, c_ifjump;
  logic [31:0] c_jumppc;

  // Reference architectural register file.
  logic [31:0] mg [32];

  typedef enum {K_NOP, K_ADDU, K_SUBU, K_ORI, K_LUI, K_LW, K_SW,
                K_BEQ, K_BNE, K_J, K_JAL, K_JR} kind_t;

  decode_stage #(.RESET_PC(RESET_PC), .NUM_REGS(32)) dut (
    .clk(clk), .reset(reset), .f_pc(f_pc), .f_instr(f_instr),
    .ifjump(ifjump), .jumppc(jumppc), .zuse(zuse),
    .e_wr_addr(e_wr_addr), .e_we(e_we), .e_is_load(e_is_load),
    .m_wr_addr(m_wr_addr), .m_we(m_we), .m_is_load(m_is_load), .m_data(m_data),
    .w_we(w_we), .w_addr(w_addr), .w_data(w_data),
    .de_pc(de_pc), .de_instr(de_instr), .de_rs_val(de_rs_val),
    .de_rt_val(de_rt_val), .de_imm(de_imm), .de_valid(de_valid)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Instruction builders.
  function automatic logic [31:0] rtype(input int rs, input int rt, input int rd, input logic [5:0] fn);
    return {6'h00, 5'(rs), 5'(rt), 5'(rd), 5'd0, fn};
  endfunction
  function automatic logic [31:0] itype(input logic [5:0] op, input int rs, input int rt, input logic [15:0] imm);
    return {op, 5'(rs), 5'(rt), imm};
  endfunction
  function automatic logic [31:0] jtype(input logic [5:0] op, input logic [25:0] idx);
    return {op, idx};
  endfunction

  function automatic kind_t classify(input logic [31:0] ins);
    logic [5:0] op, fn;
    op = ins[31:26];
    fn = ins[5:0];
    if (op == 6'h00) begin
      if (fn == 6'h21) return K_ADDU;
      if (fn == 6'h23) return K_SUBU;
      if (fn == 6'h08) return K_JR;
      return K_NOP;
    end
    case (op)
      6'h02: return K_J;
      6'h03: return K_JAL;
      6'h04: return K_BEQ;
      6'h05: return K_BNE;
      6'h0d: return K_ORI;
      6'h0f: return K_LUI;
      6'h23: return K_LW;
      6'h2b: return K_SW;
      default: return K_NOP;
    endcase
  endfunction

  // Architectural read as seen by D this cycle (W write already visible).
  function automatic logic [31:0] arch_read(input logic [4:0] a);
    if (a == 0) return 32'd0;
    if (w_we && w_addr == a) return w_data;
    return mg[a];
  endfunction

  // Value the comparator sees: newest producer wins (M ALU result, then RF).
  function automatic logic [31:0] cmp_read(input logic [4:0] a);
    if (a != 0 && m_we && !m_is_load && m_wr_addr == a) return m_data;
    return arch_read(a);
  endfunction

  // Drive one cycle, check the combinational outputs, clock, check the latch.
  task automatic step(input logic rst, input logic [31:0] pc, input logic [31:0] ins,
                      input logic [4:0] ewa, input logic ewe, input logic eld,
                      input logic [4:0] mwa, input logic mwe, input logic mld, input logic [31:0] md,
                      input logic wwe, input logic [4:0] wa, input logic [31:0] wd);
    kind_t k;
    logic [4:0] rs, rt;
    logic [31:0] sx, t_jpc, t_imm, t_rsv, t_rtv;
    logic rs_used, rt_used, rs_cmp, rt_cmp, t_zuse, t_taken, t_ifj;
    @(negedge clk);
    reset = rst; f_pc = pc; f_instr = ins;
    e_wr_addr = ewa; e_we = ewe; e_is_load = eld;
    m_wr_addr = mwa; m_we = mwe; m_is_load = mld; m_data = md;
    w_we = wwe; w_addr = wa; w_data = wd;
    #1;
    k  = classify(ins);
    rs = ins[25:21];
    rt = ins[20:16];
    sx = 32'($signed(ins[15:0]));
    rs_used = k inside {K_ADDU, K_SUBU, K_ORI, K_LW, K_SW, K_BEQ, K_BNE, K_JR};
    rt_used = k inside {K_ADDU, K_SUBU, K_SW, K_BEQ, K_BNE};
    rs_cmp  = k inside {K_BEQ, K_BNE, K_JR};
    rt_cmp  = k inside {K_BEQ, K_BNE};
    t_zuse = 1'b0;
    if (eld && ewa != 0 && ((rs_used && rs == ewa) || (rt_used && rt == ewa))) t_zuse = 1'b1;
    if (ewe && ewa != 0 && ((rs_cmp && rs == ewa) || (rt_cmp && rt == ewa))) t_zuse = 1'b1;
    if (mld && mwa != 0 && ((rs_cmp && rs == mwa) || (rt_cmp && rt == mwa))) t_zuse = 1'b1;
    if (rst) t_zuse = 1'b0;
    t_taken = 1'b0;
    t_jpc   = 32'd0;
    case (k)
      K_BEQ: begin t_taken = (cmp_read(rs) == cmp_read(rt)); t_jpc = pc + 4 + sx * 4; end
      K_BNE: begin t_taken = (cmp_read(rs) != cmp_read(rt)); t_jpc = pc + 4 + sx * 4; end
      K_J, K_JAL: begin t_taken = 1'b1; t_jpc = (pc & 32'hF000_0000) | ({6'd0, ins[25:0]} * 4); end
      K_JR: begin t_taken = 1'b1; t_jpc = cmp_read(rs); end
      default: ;
    endcase
    t_ifj = !rst && !t_zuse && t_taken;
    t_imm = (k == K_ORI) ? {16'd0, ins[15:0]} : (k == K_LUI) ? {16'd0, ins[15:0]} << 16 : sx;
    t_rsv = arch_read(rs);
    t_rtv = arch_read(rt);
    c_zuse = zuse; c_ifjump = ifjump; c_jumppc = jumppc;
    check("zuse", 32'(zuse), 32'(t_zuse));
    check("ifjump", 32'(ifjump), 32'(t_ifj));
    if (!rst) check("jumppc", jumppc, t_jpc);
    @(posedge clk);
    if (rst) for (int i = 0; i < 32; i++) mg[i] = 32'd0;
    else if (wwe && wa != 0) mg[wa] = wd;
    #1;
    if (rst) begin
      check("rst_de_pc", de_pc, RESET_PC);
      check("rst_de_valid", 32'(de_valid), 32'd0);
      check("rst_de_instr", de_instr, 32'd0);
      check("rst_de_rs", de_rs_val, 32'd0);
    end else if (t_zuse) begin
      check("bub_de_pc", de_pc, pc);
      check("bub_de_valid", 32'(de_valid), 32'd0);
      check("bub_de_instr", de_instr, 32'd0);
      check("bub_de_rs", de_rs_val, 32'd0);
      check("bub_de_imm", de_imm, 32'd0);
    end else begin
      check("de_pc", de_pc, pc);
      check("de_valid", 32'(de_valid), 32'd1);
      check("de_instr", de_instr, ins);
      check("de_rs_val", de_rs_val, t_rsv);
      check("de_rt_val", de_rt_val, t_rtv);
      check("de_imm", de_imm, t_imm);
    end
  endtask

  // Shorthand for a cycle with an empty E/M/W.
  task automatic idle_step(input logic [31:0] pc, input logic [31:0] ins);
    step(1'b0, pc, ins, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 32'd0, 1'b0, 5'd0, 32'd0);
  endtask

  function automatic logic [31:0] rand_instr();
    int r1, r2, r3;
    logic [15:0] imm;
    r1  = $urandom_range(0, 7);
    r2  = $urandom_range(0, 7);
    r3  = $urandom_range(0, 7);
    imm = 16'($urandom);
    case ($urandom_range(0, 12))
      0:  return rtype(r1, r2, r3, 6'h21);
      1:  return rtype(r1, r2, r3, 6'h23);
      2:  return itype(6'h0d, r1, r2, imm);
      3:  return itype(6'h0f, 0, r2, imm);
      4:  return itype(6'h23, r1, r2, imm);
      5:  return itype(6'h2b, r1, r2, imm);
      6:  return itype(6'h04, r1, r2, imm);
      7:  return itype(6'h05, r1, r2, imm);
      8:  return jtype(6'h02, 26'($urandom));
      9:  return jtype(6'h03, 26'($urandom));
      10: return rtype(r1, 0, 0, 6'h08);
      11: return 32'd0;
      default: return itype(6'h08, r1, r2, imm);
    endcase
  endfunction

  initial begin
    logic [31:0] lw3, addu432, beq70;
    logic eld, mld;
    reset = 1'b1; f_pc = '0; f_instr = '0;
    e_wr_addr = '0; e_we = 0; e_is_load = 0;
    m_wr_addr = '0; m_we = 0; m_is_load = 0; m_data = '0;
    w_we = 0; w_addr = '0; w_data = '0;
    for (int i = 0; i < 32; i++) mg[i] = 32'hDEAD_BEEF;

    // Reset state.
    step(1'b1, 32'h0, 32'h0, 5'd0, 0, 0, 5'd0, 0, 0, 32'd0, 0, 5'd0, 32'd0);
    check("reset_pc_lit", de_pc, 32'h3000);

    // Same-cycle W bypass of $5, then writes to $0 are ignored.
    step(1'b0, 32'h3000, rtype(5, 0, 4, 6'h21), 5'd0, 0, 0, 5'd0, 0, 0, 32'd0, 1, 5'd5, 32'h1234);
    check("bypass_lit", de_rs_val, 32'h1234);
    step(1'b0, 32'h3004, rtype(0, 0, 4, 6'h21), 5'd0, 0, 0, 5'd0, 0, 0, 32'd0, 1, 5'd0, 32'd7);
    check("r0_same_lit", de_rs_val, 32'd0);
    idle_step(32'h3008, rtype(0, 5, 4, 6'h21));
    check("r0_after_lit", de_rs_val, 32'd0);
    check("r5_kept_lit", de_rt_val, 32'h1234);

    // Load-use: one bubble, then the addu latches.
    addu432 = rtype(3, 2, 4, 6'h21);
    step(1'b0, 32'h300C, addu432, 5'd3, 1, 1, 5'd0, 0, 0, 32'd0, 0, 5'd0, 32'd0);
    check("lu_stall_lit", 32'(c_zuse), 32'd1);
    step(1'b0, 32'h300C, addu432, 5'd0, 0, 0, 5'd3, 1, 1, 32'd0, 0, 5'd0, 32'd0);
    check("lu_clear_lit", 32'(c_zuse), 32'd0);
    check("lu_valid_lit", 32'(de_valid), 32'd1);

    // beq taken / bne not taken with equal operands.
    step(1'b0, 32'h3010, rtype(0, 0, 0, 6'h00), 5'd0, 0, 0, 5'd0, 0, 0, 32'd0, 1, 5'd1, 32'hA5A5_0001);
    idle_step(32'h3010, itype(6'h04, 1, 1, 16'd3));
    check("beq_take_lit", 32'(c_ifjump), 32'd1);
    check("beq_tgt_lit", c_jumppc, 32'h3020);
    idle_step(32'h3010, itype(6'h05, 1, 1, 16'd3));
    check("bne_eq_lit", 32'(c_ifjump), 32'd0);
    idle_step(32'h3010, itype(6'h05, 1, 0, 16'hFFFF));
    check("bne_back_lit", c_jumppc, 32'h3010);

    // ALU producer in E stalls a branch; next cycle it is forwarded from M.
    beq70 = itype(6'h04, 7, 0, 16'd4);
    step(1'b0, 32'h3020, 32'd0, 5'd0, 0, 0, 5'd0, 0, 0, 32'd0, 1, 5'd7, 32'd99);
    step(1'b0, 32'h3024, beq70, 5'd7, 1, 0, 5'd0, 0, 0, 32'd0, 0, 5'd0, 32'd0);
    check("br_e_stall_lit", 32'(c_zuse), 32'd1);
    check("br_e_nojump_lit", 32'(c_ifjump), 32'd0);
    step(1'b0, 32'h3024, beq70, 5'd0, 0, 0, 5'd7, 1, 0, 32'd0, 0, 5'd0, 32'd0);
    check("br_m_fwd_lit", 32'(c_ifjump), 32'd1);
    // Load in M feeding a branch still stalls.
    step(1'b0, 32'h3024, beq70, 5'd0, 0, 0, 5'd7, 1, 1, 32'd0, 0, 5'd0, 32'd0);
    check("br_mload_lit", 32'(c_zuse), 32'd1);

    // jr using the jal link value in M; absolute jump.
    step(1'b0, 32'h3040, rtype(31, 0, 0, 6'h08), 5'd0, 0, 0, 5'd31, 1, 0, 32'h3008, 0, 5'd0, 32'd0);
    check("jr_stall_lit", 32'(c_zuse), 32'd0);
    check("jr_tgt_lit", c_jumppc, 32'h3008);
    idle_step(32'h3000, jtype(6'h02, 26'h0C04));
    check("j_tgt_lit", c_jumppc, 32'h3010);

    // Reset arriving during a load-use stall.
    lw3 = itype(6'h23, 0, 3, 16'd0);
    step(1'b0, 32'h3050, addu432, 5'd3, 1, 1, 5'd0, 0, 0, 32'd0, 0, 5'd0, 32'd0);
    step(1'b1, 32'h3050, addu432, 5'd3, 1, 1, 5'd0, 0, 0, 32'd0, 0, 5'd0, 32'd0);
    check("rst_stall_zuse_lit", 32'(c_zuse), 32'd0);
    check("rst_stall_pc_lit", de_pc, 32'h3000);
    idle_step(32'h3000, rtype(5, 1, 4, 6'h21));
    check("rst_clear5_lit", de_rs_val, 32'd0);
    check("rst_clear1_lit", de_rt_val, 32'd0);
    idle_step(32'h3004, lw3);

    // Random streams against the reference model.
    for (int n = 0; n < 600; n++) begin
      eld = ($urandom_range(0, 3) == 0);
      mld = ($urandom_range(0, 3) == 0);
      step(($urandom_range(0, 79) == 0),
           32'($urandom) & 32'hFFFF_FFFC, rand_instr(),
           5'($urandom_range(0, 7)), eld | ($urandom_range(0, 1) == 1), eld,
           5'($urandom_range(0, 7)), mld | ($urandom_range(0, 1) == 1), mld,
           ($urandom_range(0, 3) == 0) ? 32'd0 : 32'($urandom),
           ($urandom_range(0, 1) == 1), 5'($urandom_range(0, 7)), 32'($urandom));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
